// File: rtl/store_narrow.sv
// Store-path narrowing unit: byte/half/word narrowing, lane replication, byte enables and
// representability flag, behind a two-entry skid buffer. Macro STORE_NARROW_OVF_CNT_EN enables ovf_cnt_o.
module store_narrow #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [3:0]        out_be_o,
   output logic              out_ovf_o,
   output logic              out_misalign_o,
   output logic [CNT_W-1:0]  ovf_cnt_o
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [3:0]        be;
      logic              ovf;
      logic              misalign;
   } entry_t;

   state_t            state;
   entry_t            main_p1;
   entry_t            skid_p1;
   entry_t            new_p0;
   logic [DATA_W-1:0] ext_p0;
   logic              accept;
   logic              xfer;

   assign in_ready_o = (state != FULL) & ~rst_i;
   assign accept     = in_valid_i & in_ready_o;
   assign xfer       = out_valid_o & out_ready_i;

   // Stage p0: narrow, replicate and check representability of the incoming request
   always_comb begin
      new_p0      = '0;
      ext_p0      = data_i;
      new_p0.addr = {addr_i[DATA_W-1:2], 2'b00};
      case (size_i)
         2'b00: begin
            new_p0.data     = {4{data_i[7:0]}};
            new_p0.be       = 4'b0001 << addr_i[1:0];
            ext_p0          = signed_i ? {{(DATA_W-8){data_i[7]}}, data_i[7:0]}
                                       : {{(DATA_W-8){1'b0}}, data_i[7:0]};
            new_p0.misalign = 1'b0;
         end
         2'b01: begin
            new_p0.data     = {2{data_i[15:0]}};
            new_p0.be       = addr_i[1] ? 4'b1100 : 4'b0011;
            ext_p0          = signed_i ? {{(DATA_W-16){data_i[15]}}, data_i[15:0]}
                                       : {{(DATA_W-16){1'b0}}, data_i[15:0]};
            new_p0.misalign = addr_i[0];
         end
         default: begin
            // reserved size 11 behaves as a word store
            new_p0.data     = data_i;
            new_p0.be       = 4'b1111;
            ext_p0          = data_i;
            new_p0.misalign = |addr_i[1:0];
         end
      endcase
      if (new_p0.misalign) new_p0.be = 4'b0000;
      new_p0.ovf = (ext_p0 != data_i);
   end

   // Stage p1: main entry drives the memory port, skid entry absorbs one back-pressured request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= EMPTY;
         main_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_p1 <= new_p0;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  main_p1 <= new_p0;
               end else if (accept) begin
                  skid_p1 <= new_p0;
                  state   <= FULL;
               end else if (xfer) begin
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (xfer) begin
                  main_p1 <= skid_p1;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   assign out_valid_o    = (state != EMPTY);
   assign out_addr_o     = main_p1.addr;
   assign out_data_o     = main_p1.data;
   assign out_be_o       = main_p1.be;
   assign out_ovf_o      = main_p1.ovf;
   assign out_misalign_o = main_p1.misalign;

`ifdef STORE_NARROW_OVF_CNT_EN
   logic [CNT_W-1:0] ovf_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf_cnt <= '0;
      end else if (accept && new_p0.ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
         ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
   end

   assign ovf_cnt_o = ovf_cnt;
`else
   assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: queue-based reference model checked every cycle plus directed literal checks.
module tb_store_narrow;

   localparam int CNT_W = 4;
`ifdef STORE_NARROW_OVF_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      addr = '0;
   logic [31:0]      data = '0;
   logic [1:0]       size = '0;
   logic             sgn = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_addr;
   logic [31:0]      out_data;
   logic [3:0]       out_be;
   logic             out_ovf;
   logic             out_misalign;
   logic [CNT_W-1:0] ovf_cnt;

   store_narrow #(.DATA_W(32), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .addr_i(addr), .data_i(data), .size_i(size), .signed_i(sgn),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_addr_o(out_addr),
      .out_data_o(out_data), .out_be_o(out_be), .out_ovf_o(out_ovf),
      .out_misalign_o(out_misalign), .ovf_cnt_o(ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic        ovf;
      logic        mis;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   cnt_m = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Reference: what a store of this size must write, and whether the value fits the size
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] sz, input logic sg);
      exp_t e;
      int   nb;
      nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      e.addr = a & 32'hFFFF_FFFC;
      e.mis  = (a % nb) != 0;
      if (nb == 1) begin
         e.data = (d & 32'hFF) * 32'h0101_0101;
         e.be   = 4'(1 << (a % 4));
         e.ovf  = sg ? ($signed(d) < -128 || $signed(d) > 127) : (d > 255);
      end else if (nb == 2) begin
         e.data = (d & 32'hFFFF) * 32'h0001_0001;
         e.be   = ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
         e.ovf  = sg ? ($signed(d) < -32768 || $signed(d) > 32767) : (d > 65535);
      end else begin
         e.data = d;
         e.be   = 4'b1111;
         e.ovf  = 1'b0;
      end
      if (e.mis) e.be = 4'b0000;
      return e;
   endfunction

   // Inputs change just after posedge, so at negedge both outputs and the next edge's inputs are stable
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) && !rst});
         chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
         chk("ovf_cnt", {28'd0, ovf_cnt}, CNT_ON ? cnt_m : 0);
         if (q.size() > 0) begin
            chk("out_addr", out_addr, q[0].addr);
            chk("out_data", out_data, q[0].data);
            chk("out_be", {28'd0, out_be}, {28'd0, q[0].be});
            chk("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
            chk("out_mis", {31'd0, out_misalign}, {31'd0, q[0].mis});
         end
         if (rst) begin
            q.delete();
            cnt_m = 0;
         end else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               e = model(addr, data, size, sgn);
               q.push_back(e);
               if (e.ovf && cnt_m < 15) cnt_m++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; returns just after the edge that accepted the request
   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input logic sg);
      bit ok = 1'b0;
      addr = a; data = d; size = sz; sgn = sg; in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         step();
      end
      in_valid = 1'b0;
      if (!ok) begin
         failures++;
         $display("FAIL req_timeout got=stalled exp=accepted addr=%h", a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(); step();
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_addr", out_addr, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_be", {28'd0, out_be}, 32'd0);
      chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
      chk("rst_mis", {31'd0, out_misalign}, 32'd0);
      chk("rst_cnt", {28'd0, ovf_cnt}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      step();
      mon_en = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
      step();

      out_ready = 1'b1;
      req(32'h1003, 32'h0000_007F, 2'd0, 1'b1);
      @(negedge clk);
      chk("byte_valid", {31'd0, out_valid}, 32'd1);
      chk("byte_data", out_data, 32'h7F7F_7F7F);
      chk("byte_be", {28'd0, out_be}, 32'b1000);
      chk("byte_ovf", {31'd0, out_ovf}, 32'd0);
      chk("byte_addr", out_addr, 32'h1000);
      step();

      req(32'h2002, 32'hFFFF_8000, 2'd1, 1'b1);
      @(negedge clk);
      chk("half_be", {28'd0, out_be}, 32'b1100);
      chk("half_data", out_data, 32'h8000_8000);
      chk("half_s_ovf", {31'd0, out_ovf}, 32'd0);
      step();
      req(32'h2002, 32'hFFFF_8000, 2'd1, 1'b0);
      @(negedge clk);
      chk("half_u_ovf", {31'd0, out_ovf}, 32'd1);
      step();

      req(32'h3002, 32'h1234_5678, 2'd2, 1'b1);
      @(negedge clk);
      chk("word_mis", {31'd0, out_misalign}, 32'd1);
      chk("word_mis_be", {28'd0, out_be}, 32'd0);
      chk("word_mis_data", out_data, 32'h1234_5678);
      step();

      out_ready = 1'b0;
      req(32'h4000, 32'h0000_0011, 2'd0, 1'b0);
      req(32'h4002, 32'h0000_2222, 2'd1, 1'b0);
      fork
         req(32'h4004, 32'h3333_3333, 2'd2, 1'b0);
         begin
            repeat (2) begin
               @(negedge clk);
               chk("bp_ready", {31'd0, in_ready}, 32'd0);
               chk("bp_hold", out_data, 32'h1111_1111);
            end
            step();
            out_ready = 1'b1;
         end
      join
      @(negedge clk);
      chk("bp_last", out_data, 32'h3333_3333);
      step();

      for (int i = 0; i < 40; i++) req(32'h5000, 32'h0000_0100, 2'd0, 1'b1);
      @(negedge clk);
      chk("sat_cnt", {28'd0, ovf_cnt}, CNT_ON ? 32'd15 : 32'd0);
      chk("sat_ovf", {31'd0, out_ovf}, 32'd1);
      chk("sat_data", out_data, 32'd0);
      step();

      out_ready = 1'b0;
      req(32'h6000, 32'h0000_0005, 2'd0, 1'b0);
      req(32'h6001, 32'h0000_0006, 2'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", {31'd0, in_ready}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_cnt", {28'd0, ovf_cnt}, 32'd0);
      chk("midrst_ready1", {31'd0, in_ready}, 32'd1);
      chk("midrst_data", out_data, 32'd0);
      step();

      for (int i = 0; i < 8; i++) begin
         out_ready = i[0];
         case (i % 4)
            0: req(32'h7000 + i, 32'h0000_00FF, 2'd0, 1'b0);
            1: req(32'h7001 + i, 32'h0000_00FF, 2'd0, 1'b1);
            2: req(32'h7001 + i, 32'h0001_1234, 2'd1, 1'b0);
            default: req(32'h7008 + i, 32'hDEAD_BEEF, 2'd3, 1'b1);
         endcase
      end
      req(32'h7102, 32'hFFFF_FF80, 2'd0, 1'b1);
      out_ready = 1'b1;
      repeat (4) step();
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
